calc2_resp_merge: RTL and testbench

// Downstream of calc2_top: captures the four per-port response streams (out_respN/out_dataN/out_tagN),

---
 rtl/calc2_pkg.sv | 23 ++
 rtl/calc2_resp_fifo.sv | 47 ++++
 rtl/calc2_resp_merge.sv | 130 +++++++++++++
 tb/tb_calc2_resp_merge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// calc2_pkg: shared response codes, command codes and the buffered response beat type
package calc2_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;

    localparam logic [1:0] RESP_NONE   = 2'b00;
    localparam logic [1:0] RESP_OK     = 2'b01;
    localparam logic [1:0] RESP_ERR    = 2'b10;
    localparam logic [1:0] RESP_UNUSED = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'h1;
    localparam logic [3:0] CMD_SUB = 4'h2;
    localparam logic [3:0] CMD_SHL = 4'h5;
    localparam logic [3:0] CMD_SHR = 4'h6;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } resp_beat_t;

endpackage

// File: rtl/calc2_resp_fifo.sv
// calc2_resp_fifo: single-clock FIFO of response beats; a push into a full FIFO is taken when a pop happens the same edge
module calc2_resp_fifo
    import calc2_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  resp_beat_t i_din,
    input  logic       i_pop,
    output resp_beat_t o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    resp_beat_t  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_wr_en;
    logic        w_rd_en;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_dout  = r_mem[r_rd[AW-1:0]];

    // read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + (AW+1)'(w_wr_en);
            r_rd <= r_rd + (AW+1)'(w_rd_en);
        end
    end

    // storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/calc2_resp_merge.sv
// calc2_resp_merge: buffers per-port calc2 responses and merges them round-robin into one valid/ready stream
module calc2_resp_merge
    import calc2_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
)(
    input  logic                              i_c_clk,
    input  logic                              i_reset_n,
    input  logic [NPORTS-1:0][1:0]            i_resp_in,
    input  logic [NPORTS-1:0][DATA_W-1:0]     i_data_in,
    input  logic [NPORTS-1:0][TAG_W-1:0]      i_tag_in,
    input  logic                              i_clr_ovf,
    output logic                              o_m_valid,
    input  logic                              i_m_ready,
    output logic [$clog2(NPORTS)-1:0]         o_m_port,
    output logic [1:0]                        o_m_resp,
    output logic [DATA_W-1:0]                 o_m_data,
    output logic [TAG_W-1:0]                  o_m_tag,
    output logic [NPORTS-1:0]                 o_ovf,
    output logic [CNT_W-1:0]                  o_ok_count,
    output logic [CNT_W-1:0]                  o_err_count
);

    localparam int PW = $clog2(NPORTS);

    resp_beat_t        w_din  [NPORTS];
    resp_beat_t        w_dout [NPORTS];
    logic [NPORTS-1:0] w_push, w_pop, w_full, w_empty, w_ovf_set, w_acc;
    logic              w_load, w_any;
    logic [PW-1:0]     w_grant;
    logic [CNT_W:0]    w_ok_inc, w_err_inc, w_ok_sum, w_err_sum;

    logic              r_valid;
    logic [PW-1:0]     r_port;
    logic [PW-1:0]     r_rr;
    resp_beat_t        r_beat;
    logic [NPORTS-1:0] r_ovf;
    logic [CNT_W-1:0]  r_ok;
    logic [CNT_W-1:0]  r_err;

    // the output register may take a new beat whenever it is empty or its beat is being consumed
    assign w_load = !r_valid || i_m_ready;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign w_din[g]     = {i_resp_in[g], i_data_in[g], i_tag_in[g]};
        assign w_push[g]    = |i_resp_in[g];
        assign w_pop[g]     = w_load && w_any && (w_grant == PW'(g));
        assign w_ovf_set[g] = w_push[g] && w_full[g] && !w_pop[g];
        assign w_acc[g]     = w_push[g] && !w_ovf_set[g];

        calc2_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk   (i_c_clk),
            .i_rst_n (i_reset_n),
            .i_push  (w_push[g]),
            .i_din   (w_din[g]),
            .i_pop   (w_pop[g]),
            .o_dout  (w_dout[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // round-robin grant: first nonempty FIFO at or after the pointer (downward scan so the nearest wins)
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (!w_empty[(int'(r_rr) + i) % NPORTS]) begin
                w_any   = 1'b1;
                w_grant = PW'((int'(r_rr) + i) % NPORTS);
            end
        end
    end

    // per-edge popcount of accepted pushes, split by response class, then saturating sums
    always_comb begin
        w_ok_inc  = '0;
        w_err_inc = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_acc[p]) begin
                if (i_resp_in[p] == RESP_OK) w_ok_inc  = w_ok_inc + (CNT_W+1)'(1);
                else                         w_err_inc = w_err_inc + (CNT_W+1)'(1);
            end
        end
        w_ok_sum  = {1'b0, r_ok} + w_ok_inc;
        w_err_sum = {1'b0, r_err} + w_err_inc;
    end

    // output register and round-robin pointer
    always_ff @(posedge i_c_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_port  <= '0;
            r_beat  <= '0;
            r_rr    <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_port <= w_grant;
                r_beat <= w_dout[w_grant];
                r_rr   <= PW'((int'(w_grant) + 1) % NPORTS);
            end
        end
    end

    // sticky overflow flags (a new overflow beats a same-edge clear) and saturating counters
    always_ff @(posedge i_c_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovf <= '0;
            r_ok  <= '0;
            r_err <= '0;
        end else begin
            r_ovf <= (i_clr_ovf ? '0 : r_ovf) | w_ovf_set;
            r_ok  <= w_ok_sum[CNT_W]  ? '1 : w_ok_sum[CNT_W-1:0];
            r_err <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        end
    end

    assign o_m_valid   = r_valid;
    assign o_m_port    = r_port;
    assign o_m_resp    = r_beat.resp;
    assign o_m_data    = r_beat.data;
    assign o_m_tag     = r_beat.tag;
    assign o_ovf       = r_ovf;
    assign o_ok_count  = r_ok;
    assign o_err_count = r_err;

endmodule

// File: tb/tb_calc2_resp_merge.sv
// tb_calc2_resp_merge: table, directed and random checks of calc2_resp_merge against a queue-based reference model
module tb_calc2_resp_merge;

    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0][1:0]   resp = '0;
    logic [3:0][31:0]  data = '0;
    logic [3:0][1:0]   tag = '0;
    logic              clr = 1'b0;
    logic              ready = 1'b1;

    logic              m_valid, s_valid;
    logic [1:0]        m_port, s_port, m_resp, s_resp, m_tag, s_tag;
    logic [31:0]       m_data, s_data;
    logic [3:0]        ovf, s_ovf;
    logic [15:0]       ok, err;
    logic [2:0]        s_ok, s_err;

    calc2_resp_merge dut (
        .i_c_clk(clk), .i_reset_n(reset_n), .i_resp_in(resp), .i_data_in(data), .i_tag_in(tag),
        .i_clr_ovf(clr), .o_m_valid(m_valid), .i_m_ready(ready), .o_m_port(m_port), .o_m_resp(m_resp),
        .o_m_data(m_data), .o_m_tag(m_tag), .o_ovf(ovf), .o_ok_count(ok), .o_err_count(err)
    );

    calc2_resp_merge #(.CNT_W(3)) u_sat (
        .i_c_clk(clk), .i_reset_n(reset_n), .i_resp_in(resp), .i_data_in(data), .i_tag_in(tag),
        .i_clr_ovf(clr), .o_m_valid(s_valid), .i_m_ready(ready), .o_m_port(s_port), .o_m_resp(s_resp),
        .o_m_data(s_data), .o_m_tag(s_tag), .o_ovf(s_ovf), .o_ok_count(s_ok), .o_err_count(s_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } mb_t;

    mb_t        mq [NP][$];
    bit         mv;
    int         mport;
    mb_t        mbeat;
    int         rr;
    logic [3:0] movf;
    int         mok, merr;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        mv = 0; mport = 0; mbeat = '0; rr = 0; movf = '0; mok = 0; merr = 0;
    endfunction

    // one clock edge: the consumer side takes a beat first, then each port's response is queued if there is room
    function automatic void model_step();
        int  g;
        mb_t b;
        g = -1;
        if (!mv || ready) begin
            for (int i = 0; i < NP; i++)
                if (g < 0 && mq[(rr + i) % NP].size() > 0) g = (rr + i) % NP;
            mv = (g >= 0);
            if (g >= 0) begin
                mbeat = mq[g].pop_front();
                mport = g;
                rr    = (g + 1) % NP;
            end
        end
        if (clr) movf = '0;
        for (int p = 0; p < NP; p++) begin
            if (resp[p] != 2'b00) begin
                if (mq[p].size() < DEPTH) begin
                    b.resp = resp[p]; b.data = data[p]; b.tag = tag[p];
                    mq[p].push_back(b);
                    if (resp[p] == 2'b01) mok++;
                    else merr++;
                end else movf[p] = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        chk("m_valid", m_valid, mv);
        if (mv) begin
            chk("m_port", m_port, mport);
            chk("m_resp", m_resp, mbeat.resp);
            chk("m_data", m_data, mbeat.data);
            chk("m_tag", m_tag, mbeat.tag);
        end
        chk("ovf", ovf, movf);
        chk("ok_count", ok, sat(mok, 65535));
        chk("err_count", err, sat(merr, 65535));
        chk("ok_count_w3", s_ok, sat(mok, 7));
        chk("err_count_w3", s_err, sat(merr, 7));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", m_valid, 0);
        chk("rst_port", m_port, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  resp;
        logic [31:0] data;
        logic [7:0]  tag;
        bit          ev;
        logic [1:0]  ep;
        logic [1:0]  er;
        logic [31:0] ed;
        int          eok;
        int          eerr;
    } vec_t;

    function automatic vec_t mk(bit rs, logic [7:0] r, logic [31:0] d, logic [7:0] t, bit ev,
                                logic [1:0] ep, logic [1:0] er, logic [31:0] ed, int eok, int eerr);
        vec_t v;
        v.rst = rs; v.resp = r; v.data = d; v.tag = t; v.ev = ev;
        v.ep = ep; v.er = er; v.ed = ed; v.eok = eok; v.eerr = eerr;
        return v;
    endfunction

    vec_t      tbl [13];
    int        got [$];
    int        prev;
    int        lvl;

    initial begin
        // port p receives data<<p; expectations are after the edge that applies the row
        tbl[0]  = mk(1, 8'h01, 32'h159, 8'h01, 0, 0, 0, 0,       1, 0);
        tbl[1]  = mk(0, 8'h00, 32'h0,   8'h00, 1, 0, 1, 32'h159, 1, 0);
        tbl[2]  = mk(0, 8'h00, 32'h0,   8'h00, 0, 0, 0, 0,       1, 0);
        tbl[3]  = mk(1, 8'h55, 32'hA0,  8'hE4, 0, 0, 0, 0,       4, 0);
        tbl[4]  = mk(0, 8'h00, 32'h0,   8'h00, 1, 0, 1, 32'hA0,  4, 0);
        tbl[5]  = mk(0, 8'h00, 32'h0,   8'h00, 1, 1, 1, 32'h140, 4, 0);
        tbl[6]  = mk(0, 8'h00, 32'h0,   8'h00, 1, 2, 1, 32'h280, 4, 0);
        tbl[7]  = mk(0, 8'h00, 32'h0,   8'h00, 1, 3, 1, 32'h500, 4, 0);
        tbl[8]  = mk(0, 8'h00, 32'h0,   8'h00, 0, 0, 0, 0,       4, 0);
        tbl[9]  = mk(0, 8'h80, 32'h0,   8'h00, 0, 0, 0, 0,       4, 1);
        tbl[10] = mk(0, 8'hC0, 32'h0,   8'h00, 1, 3, 2, 32'h0,   4, 2);
        tbl[11] = mk(0, 8'h00, 32'h0,   8'h00, 1, 3, 3, 32'h0,   4, 2);
        tbl[12] = mk(0, 8'h00, 32'h0,   8'h00, 0, 0, 0, 0,       4, 2);

        model_reset();
        ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            resp = tbl[i].resp;
            tag  = tbl[i].tag;
            for (int p = 0; p < NP; p++) data[p] = tbl[i].data << p;
            cyc();
            chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_port", i), m_port, tbl[i].ep);
                chk($sformatf("tbl%0d_resp", i), m_resp, tbl[i].er);
                chk($sformatf("tbl%0d_data", i), m_data, tbl[i].ed);
            end
            chk($sformatf("tbl%0d_ok", i), ok, tbl[i].eok);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].eerr);
        end
        resp = '0;

        // overflow on port 2 while the consumer stalls, then in-order drain and flag clear
        do_reset();
        ready = 1'b0;
        tag = '0;
        for (int k = 1; k <= 6; k++) begin
            resp = '0;
            resp[2] = 2'b01;
            data[2] = k;
            cyc();
        end
        resp = '0;
        chk("t3_ovf", ovf, 4'b0100);
        chk("t3_ok", ok, 5);
        ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_valid) got.push_back(int'(m_data));
            cyc();
        end
        chk("t3_count", got.size(), 5);
        for (int i = 0; i < got.size(); i++) chk("t3_order", got[i], i + 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t3_clr", ovf, 0);

        // asynchronous reset while beats are still queued
        do_reset();
        ready = 1'b0;
        resp = 8'h15;
        data[0] = 32'h11; data[1] = 32'h22; data[2] = 32'h33;
        cyc();
        resp = '0;
        cyc();
        ready = 1'b1;
        cyc();
        chk("t5_pre_valid", m_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", m_valid, 0);
        chk("t5_async_ok", ok, 0);
        chk("t5_async_err", err, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("t5_stale", m_valid, 0);
        end

        // ports 0 and 1 alternate one response per cycle: output alternates, nothing overflows
        do_reset();
        ready = 1'b1;
        prev = -1;
        for (int c = 0; c < 24; c++) begin
            resp = '0;
            resp[c % 2] = 2'b01;
            data[c % 2] = c;
            cyc();
            if (m_valid) begin
                if (prev >= 0) chk("t6_alt", m_port, prev == 0 ? 1 : 0);
                prev = int'(m_port);
            end
        end
        resp = '0;
        chk("t6_ovf", ovf, 0);

        // four pushes per edge into a 3-bit counter: 4 then 8 saturates at 7
        do_reset();
        resp = 8'h55;
        cyc();
        chk("sat_w3_first", s_ok, 4);
        cyc();
        resp = '0;
        chk("sat_w3_ok", s_ok, 7);
        chk("sat_w16_ok", ok, 8);

        // random traffic with varying load, stalls, clears and occasional resets
        do_reset();
        lvl = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) lvl = int'($urandom_range(1, 12));
            for (int p = 0; p < NP; p++) begin
                resp[p] = ($urandom_range(0, 15) < lvl) ? 2'($urandom_range(1, 3)) : 2'b00;
                data[p] = $urandom;
                tag[p]  = 2'($urandom_range(0, 3));
            end
            ready = $urandom_range(0, 9) < 7;
            clr   = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc();
        end
        resp = '0;
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
